// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads the word at PC over a mem_req/mem_ack handshake and strobes it into the IR.
// Optional HALT-word detection is built when FETCH_HALT_DETECT_EN is defined.
module instr_fetch #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              ir_load,
  output logic [15:0]       ir_data,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_LOAD   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [15:0] HALT_WORD = 16'hE000;

  state_t state;

  assign state_dbg = state;

  // Handshake: mem_req rises with mem_addr and both stay stable until the
  // single-cycle mem_ack; mem_rdata is taken only in that ack cycle, and
  // an ack seen in any other state is dropped.
`ifdef FETCH_HALT_DETECT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      ir_load  <= 1'b0;
      ir_data  <= 16'h0000;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      ir_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch_req) begin
            state    <= S_REQ;
            mem_req  <= 1'b1;
            mem_addr <= pc;
            busy     <= 1'b1;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            ir_data <= mem_rdata;
            mem_req <= 1'b0;
            ir_load <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          pc   <= pc + 1'b1;
          busy <= 1'b0;
          // The HALT word is still delivered to the IR before stopping.
          if (ir_data == HALT_WORD) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALTED: begin
          if (pc_load) begin
            state  <= S_IDLE;
            halted <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
      // A redirect overrides the post-fetch increment.
      if (pc_load) begin
        pc <= pc_load_val;
      end
    end
  end
`else
  assign halted = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      ir_load  <= 1'b0;
      ir_data  <= 16'h0000;
      busy     <= 1'b0;
    end else begin
      ir_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch_req) begin
            state    <= S_REQ;
            mem_req  <= 1'b1;
            mem_addr <= pc;
            busy     <= 1'b1;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            ir_data <= mem_rdata;
            mem_req <= 1'b0;
            ir_load <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          pc    <= pc + 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
      // A redirect overrides the post-fetch increment.
      if (pc_load) begin
        pc <= pc_load_val;
      end
    end
  end
`endif

endmodule
